frame_stage_sequencer: RTL and testbench
========================================

Name: frame_stage_sequencer

Overview:
Sequences the image datapath for one frame after the parameter controller pulses new_trans. It latches the image dimensions and runs NUM_STAGES processing passes in order (stage 0 = Gaussian blur, stage 1 = FAST detect, ...). Each pass uses a raster coordinate stream with a valid/ready handshake. When the last stage has drained, it pulses img_done back to the parameter controller.

Parameters:
X_MAX, 400, maximum image width; coordinate/dimension width XW = $clog2(X_MAX)
Y_MAX, 400, maximum image height; YW = $clog2(Y_MAX)
NUM_STAGES, 2, number of sequential passes per frame (>=1); SW = max(1, $clog2(NUM_STAGES))

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous, active-low reset
new_trans  in  1  one-cycle start pulse from the parameter controller
max_x  in  XW  image width in pixels, sampled on new_trans
max_y  in  YW  image height in pixels, sampled on new_trans
stage_sel  out  SW  index of the active stage
stage_start  out  1  one-cycle pulse at the beginning of each stage
coord_x  out  XW  current raster column
coord_y  out  YW  current raster row
coord_valid  out  1  coordinate is presented
coord_ready  in  1  active stage accepts the coordinate
stage_drained  in  1  active stage pipeline is empty
busy  out  1  high whenever state != IDLE
img_done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (asynchronous, any state): state=IDLE; stage_sel=0; coord_x=0; coord_y=0; latched dims=0; all outputs 0.
- All outputs are registered state or decoded from registered state. No combinational path from coord_ready to coord_valid.
- States: IDLE, START, RUN, DRAIN, DONE.
- IDLE:
  - new_trans=1 with max_x!=0 and max_y!=0: latch dims, stage_sel=0, next state START.
  - new_trans=1 with either dimension 0: next state DONE. No stage runs and no stage_start is issued.
  - new_trans=0: stay in IDLE.
- START: stage_start=1 for exactly this cycle; coord_x=coord_y=0; next state RUN.
- RUN:
  - coord_valid=1 and coordinates are held stable until coord_valid&&coord_ready.
  - On each accept: if coord_x==lx-1, then coord_x=0 and coord_y++; otherwise coord_x++.
  - Accept of (lx-1, ly-1): next state DRAIN and coord_valid drops on the following cycle.
  - Exactly lx*ly accepts occur per stage.
- DRAIN: coord_valid=0. stage_drained is sampled only in this state. When stage_drained=1:
  - if stage_sel==NUM_STAGES-1, next state DONE;
  - otherwise stage_sel++ and next state START.
- DONE: img_done=1 for exactly one cycle; next state IDLE. stage_sel holds until the next frame.
- new_trans while busy is ignored; latched dims are unchanged.
- Input changes on max_x/max_y after latching have no effect.
- Latency, no backpressure, stage_drained already high: per stage = 1 (START) + lx*ly (RUN) + 1 (DRAIN). new_trans at cycle 0 gives img_done at cycle 1 + NUM_STAGES*(lx*ly+2).
- Counter arithmetic is unsigned at XW/YW. Comparisons use latched dims minus 1, which are safe because zero dims never reach RUN.

Test Plan:
- 3x2 image, NUM_STAGES=2, ready=1, drained=1, new_trans at c0:
  - stage_start at c1 and c9;
  - coords (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on c2-c7 and c10-c15;
  - stage_sel=1 from c9;
  - img_done only at c17;
  - busy high c1-c17.
- Backpressure, 3x2 image, coord_ready toggling 1,0,1,0,...: coords hold while ready=0, the sequence is identical to the previous test, and exactly 6 accepts occur per stage.
- Drain stall: hold stage_drained=0 for 5 cycles in DRAIN. Stays in DRAIN with coord_valid=0; stage 1 START occurs the cycle after drained rises.
- Zero dimension: new_trans with max_x=0, max_y=4. img_done next cycle, no stage_start, no coord_valid.
- new_trans re-pulsed mid-RUN with max_x=9: ignored; the original 3x2 raster completes unchanged.
- Assert n_rst mid-RUN at coord (1,1) of stage 1: all outputs 0 immediately. After release, a fresh new_trans restarts from stage 0 at (0,0).

Source files
------------

// File: rtl/frame_stage_sequencer_if.sv
// Signal bundle between the frame sequencer, the parameter controller and the stage datapath.
// master = sequencer side, slave = controller/datapath side.
interface frame_stage_sequencer_if #(
  parameter int X_MAX      = 400,
  parameter int Y_MAX      = 400,
  parameter int NUM_STAGES = 2
);
  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic          new_trans;
  logic [XW-1:0] max_x;
  logic [YW-1:0] max_y;
  logic [SW-1:0] stage_sel;
  logic          stage_start;
  logic [XW-1:0] coord_x;
  logic [YW-1:0] coord_y;
  logic          coord_valid;
  logic          coord_ready;
  logic          stage_drained;
  logic          busy;
  logic          img_done;

  modport master (
    input  new_trans, max_x, max_y, coord_ready, stage_drained,
    output stage_sel, stage_start, coord_x, coord_y, coord_valid, busy, img_done
  );

  modport slave (
    output new_trans, max_x, max_y, coord_ready, stage_drained,
    input  stage_sel, stage_start, coord_x, coord_y, coord_valid, busy, img_done
  );
endinterface

// File: rtl/frame_stage_sequencer.sv
// Runs NUM_STAGES raster passes per frame; per stage 1 START + lx*ly RUN + >=1 DRAIN cycles.
// Coordinates hold while coord_ready is low; DRAIN waits for stage_drained. All outputs registered.
module frame_stage_sequencer #(
  parameter int X_MAX      = 400,
  parameter int Y_MAX      = 400,
  parameter int NUM_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  frame_stage_sequencer_if.master bus
);
  localparam int XW = $clog2(X_MAX);
  localparam int YW = $clog2(Y_MAX);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;

  state_t        state_q;
  logic [XW-1:0] lx_q, x_q, x_d;
  logic [YW-1:0] ly_q, y_q, y_d;
  logic [SW-1:0] stage_q;
  logic          start_q, valid_q, busy_q, done_q;
  logic          accept, last_col, last_pix;

  // Dims are nonzero whenever RUN is reached, so the minus-one compares cannot wrap.
  assign accept   = valid_q && bus.coord_ready;
  assign last_col = (x_q == lx_q - XW'(1));
  assign last_pix = last_col && (y_q == ly_q - YW'(1));

  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (last_col) begin
      x_d = '0;
      y_d = y_q + YW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      lx_q    <= '0;
      ly_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      stage_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.new_trans) begin
            busy_q <= 1'b1;
            if (bus.max_x != '0 && bus.max_y != '0) begin
              lx_q    <= bus.max_x;
              ly_q    <= bus.max_y;
              stage_q <= '0;
              x_q     <= '0;
              y_q     <= '0;
              start_q <= 1'b1;
              state_q <= START;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        START: begin
          valid_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (accept) begin
            x_q <= x_d;
            y_q <= y_d;
            if (last_pix) begin
              valid_q <= 1'b0;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.stage_drained) begin
            if (stage_q == LAST_STAGE) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              stage_q <= stage_q + SW'(1);
              x_q     <= '0;
              y_q     <= '0;
              start_q <= 1'b1;
              state_q <= START;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.stage_sel   = stage_q;
  assign bus.stage_start = start_q;
  assign bus.coord_x     = x_q;
  assign bus.coord_y     = y_q;
  assign bus.coord_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.img_done    = done_q;
endmodule

// File: tb/tb_frame_stage_sequencer.sv
// Scoreboard bench: each accepted new_trans pushes the expected stage starts, accepted
// coordinates and frame-done event; a negedge monitor pops and compares them.
module tb_frame_stage_sequencer;
  localparam int NS = 2;
  localparam int XW = $clog2(400);
  localparam int YW = $clog2(400);

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  frame_stage_sequencer_if #(.X_MAX(400), .Y_MAX(400), .NUM_STAGES(NS)) bus ();
  frame_stage_sequencer #(.X_MAX(400), .Y_MAX(400), .NUM_STAGES(NS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    int stg;
    int x;
    int y;
    int cyc;
  } ev_t;

  ev_t acc_q[$];
  ev_t start_q[$];
  ev_t done_q[$];
  ev_t me;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  pending = 1'b0;
  int  issue_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard fronts.
  always @(negedge clk) begin
    if (n_rst) begin
      check("busy", int'(bus.busy), int'(pending && (cyc > issue_cyc)));
      if (bus.stage_start) begin
        if (start_q.size() == 0) check("stray_stage_start", 1, 0);
        else begin
          me = start_q.pop_front();
          check("start_stage", int'(bus.stage_sel), me.stg);
          if (me.cyc >= 0) check("start_cycle", cyc, me.cyc);
        end
      end
      if (bus.coord_valid) begin
        if (acc_q.size() == 0) check("stray_coord_valid", 1, 0);
        else begin
          me = acc_q[0];
          check("coord_stage", int'(bus.stage_sel), me.stg);
          check("coord_x", int'(bus.coord_x), me.x);
          check("coord_y", int'(bus.coord_y), me.y);
          if (bus.coord_ready) begin
            if (me.cyc >= 0) check("accept_cycle", cyc, me.cyc);
            void'(acc_q.pop_front());
          end
        end
      end
      if (bus.img_done) begin
        if (done_q.size() == 0) check("stray_img_done", 1, 0);
        else begin
          me = done_q.pop_front();
          if (me.cyc >= 0) check("done_cycle", cyc, me.cyc);
          check("done_accepts_left", acc_q.size(), 0);
          check("done_starts_left", start_q.size(), 0);
        end
        pending = 1'b0;
      end
    end
  end

  // Reference model: a frame is the ordered list of stages, each a full raster of mx*my pixels.
  task automatic issue(input int mx, input int my, input bit timed);
    int n = mx * my;
    bus.new_trans = 1'b1;
    bus.max_x = XW'(mx);
    bus.max_y = YW'(my);
    if (!pending) begin
      if (mx == 0 || my == 0) begin
        done_q.push_back('{0, 0, 0, cyc + 1});
      end else begin
        for (int s = 0; s < NS; s++) begin
          start_q.push_back('{s, 0, 0, timed ? cyc + 1 + s * (n + 2) : -1});
          for (int yy = 0; yy < my; yy++)
            for (int xx = 0; xx < mx; xx++)
              acc_q.push_back('{s, xx, yy, timed ? cyc + 2 + s * (n + 2) + yy * mx + xx : -1});
        end
        done_q.push_back('{0, 0, 0, timed ? cyc + 1 + NS * (n + 2) : -1});
      end
      pending = 1'b1;
      issue_cyc = cyc;
    end
    @(posedge clk); #1;
    bus.new_trans = 1'b0;
    bus.max_x = XW'($urandom_range(0, 399));
    bus.max_y = YW'($urandom_range(0, 399));
  endtask

  // mode 0: ready/drained high; 1: ready toggles; 2: random ready/drained plus ignored re-pulses.
  task automatic run_frame(input int mode, input int budget);
    int k = 0;
    while (pending && k < budget) begin
      case (mode)
        0: begin bus.coord_ready = 1'b1; bus.stage_drained = 1'b1; end
        1: begin bus.coord_ready = (k % 2 == 0); bus.stage_drained = 1'b1; end
        default: begin
          bus.coord_ready   = ($urandom_range(0, 1) == 1);
          bus.stage_drained = ($urandom_range(0, 2) != 0);
          bus.new_trans     = ($urandom_range(0, 7) == 0);
          bus.max_x         = XW'($urandom_range(0, 9));
          bus.max_y         = YW'($urandom_range(0, 9));
        end
      endcase
      @(posedge clk); #1;
      k++;
    end
    bus.new_trans = 1'b0;
    check("frame_timeout", int'(pending), 0);
    check("frame_accepts_left", acc_q.size(), 0);
    check("frame_done_left", done_q.size(), 0);
    pending = 1'b0;
    acc_q.delete();
    start_q.delete();
    done_q.delete();
  endtask

  initial begin
    int k;
    int c0;
    bus.new_trans = 1'b0;
    bus.max_x = '0;
    bus.max_y = '0;
    bus.coord_ready = 1'b0;
    bus.stage_drained = 1'b0;

    #3;
    check("rst_stage_sel", int'(bus.stage_sel), 0);
    check("rst_stage_start", int'(bus.stage_start), 0);
    check("rst_coord_x", int'(bus.coord_x), 0);
    check("rst_coord_y", int'(bus.coord_y), 0);
    check("rst_coord_valid", int'(bus.coord_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_img_done", int'(bus.img_done), 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;

    // 3x2 frame, no backpressure, exact cycle stamps.
    bus.coord_ready = 1'b1;
    bus.stage_drained = 1'b1;
    issue(3, 2, 1'b1);
    run_frame(0, 200);

    // Same frame with coord_ready toggling.
    issue(3, 2, 1'b0);
    run_frame(1, 200);

    // Drain stall: five cycles of stage_drained=0 after stage 0 finishes.
    bus.coord_ready = 1'b1;
    bus.stage_drained = 1'b0;
    issue(3, 2, 1'b0);
    k = 0;
    while (acc_q.size() > 6 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("stall_reach_drain", int'(k < 100), 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.stage_drained = 1'b1;
    if (start_q.size() > 0) start_q[0].cyc = cyc + 1;
    run_frame(0, 200);

    // Zero dimension: immediate done, nothing else.
    issue(0, 4, 1'b1);
    run_frame(0, 50);

    // Re-pulse mid-RUN with different dims must not disturb the timed raster.
    issue(3, 2, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.new_trans = 1'b1;
    bus.max_x = XW'(9);
    bus.max_y = YW'(3);
    @(posedge clk); #1;
    bus.new_trans = 1'b0;
    run_frame(0, 200);

    // Async reset at stage 1 coordinate (1,1), then a fresh frame.
    issue(3, 2, 1'b1);
    c0 = issue_cyc;
    k = 0;
    while (cyc < c0 + 14 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("pre_rst_stage", int'(bus.stage_sel), 1);
    check("pre_rst_x", int'(bus.coord_x), 1);
    check("pre_rst_y", int'(bus.coord_y), 1);
    #1 n_rst = 1'b0;
    #1;
    check("mid_rst_stage_sel", int'(bus.stage_sel), 0);
    check("mid_rst_coord_x", int'(bus.coord_x), 0);
    check("mid_rst_coord_y", int'(bus.coord_y), 0);
    check("mid_rst_coord_valid", int'(bus.coord_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_stage_start", int'(bus.stage_start), 0);
    check("mid_rst_img_done", int'(bus.img_done), 0);
    pending = 1'b0;
    acc_q.delete();
    start_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
    issue(3, 2, 1'b1);
    run_frame(0, 200);

    // Randomized frames.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      bus.coord_ready = ($urandom_range(0, 1) == 1);
      bus.stage_drained = ($urandom_range(0, 1) == 1);
      issue($urandom_range(0, 5), $urandom_range(0, 4), 1'b0);
      run_frame(2, 2000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end
endmodule
